vpg_mode_ctrl: RTL

- Parametrised mode and PLL-reconfiguration sequencer for the video pattern generator path; the next generation of the fixed-mode VPG control logic.
- Holds a run-time-writable table of NUM_MODES timing entries and applies a requested mode by driving the external PLL reconfig controller handshake.
- Waits for PLL lock, with timeout and retry, then pulses timing_change to the VGA timing generator.
- Sits between the host/config logic and the gen_pll / pll_reconfig / vga_time_generator instances.

---
 rtl/vpg_pkg.sv | 36 +++
 rtl/vpg_mode_table.sv | 75 +++++++
 rtl/vpg_mode_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vpg_pkg.sv
// Shared constants for the video pattern generator mode path: table field
// indices, sequencer states, well-known mode slots and PLL ROM selects.
package vpg_pkg;

  localparam logic [3:0] FLD_H_DISP   = 4'd0;
  localparam logic [3:0] FLD_H_FPORCH = 4'd1;
  localparam logic [3:0] FLD_H_SYNC   = 4'd2;
  localparam logic [3:0] FLD_H_BPORCH = 4'd3;
  localparam logic [3:0] FLD_V_DISP   = 4'd4;
  localparam logic [3:0] FLD_V_FPORCH = 4'd5;
  localparam logic [3:0] FLD_V_SYNC   = 4'd6;
  localparam logic [3:0] FLD_V_BPORCH = 4'd7;
  localparam logic [3:0] FLD_FLAGS    = 4'd8;
  localparam logic [3:0] FLD_PLL_SEL  = 4'd9;

  localparam int NUM_TIM = 8;

  typedef enum logic [3:0] {
    ST_LOAD, ST_PLL_INIT, ST_RD, ST_RD_DONE, ST_UPD, ST_UPD_DONE,
    ST_WAIT_LOCK, ST_START, ST_IDLE, ST_ERROR
  } vpg_state_e;

  localparam int VGA_640x480p60    = 0;
  localparam int SVGA_800x600p60   = 1;
  localparam int XGA_1024x768p60   = 2;
  localparam int SXGA_1280x1024p60 = 3;
  localparam int FHD_1920x1080p60  = 4;

  localparam int PLL_25  = 0;
  localparam int PLL_40  = 1;
  localparam int PLL_65  = 2;
  localparam int PLL_108 = 3;
  localparam int PLL_148 = 4;
  localparam int PLL_162 = 5;

endpackage

// File: rtl/vpg_mode_table.sv
// Run-time writable mode timing table; one full read port for the target
// entry and a validity probe that sees a same-cycle write.
module vpg_mode_table
  import vpg_pkg::*;
#(
  parameter int NUM_MODES = 8,
  parameter int MODE_W    = 3,
  parameter int TW        = 12,
  parameter int SEL_W     = 3
) (
  input  logic                           clk_100,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [MODE_W-1:0]              wr_mode,
  input  logic [3:0]                     wr_field,
  input  logic [TW-1:0]                  wr_data,
  input  logic [MODE_W-1:0]              rd_mode,
  output logic [NUM_TIM-1:0][TW-1:0]     rd_tim,
  output logic [2:0]                     rd_flags,
  output logic [SEL_W-1:0]               rd_sel,
  input  logic [MODE_W-1:0]              chk_mode,
  output logic                           chk_ok
);
  localparam int IW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  logic [NUM_MODES-1:0][NUM_TIM-1:0][TW-1:0] tim_q, tim_d;
  logic [NUM_MODES-1:0][2:0]                 flags_q, flags_d;
  logic [NUM_MODES-1:0][SEL_W-1:0]           sel_q, sel_d;
  logic [IW-1:0] wr_idx, rd_idx, chk_idx;
  logic [TW-1:0] chk_h, chk_v;

  assign wr_idx  = IW'(wr_mode);
  assign rd_idx  = IW'(rd_mode);
  assign chk_idx = IW'(chk_mode);

  always_comb begin
    tim_d   = tim_q;
    flags_d = flags_q;
    sel_d   = sel_q;
    if (wr_en && (32'(wr_mode) < NUM_MODES)) begin
      if (wr_field < FLD_FLAGS)          tim_d[wr_idx][wr_field[2:0]] = wr_data;
      else if (wr_field == FLD_FLAGS)    flags_d[wr_idx] = wr_data[2:0];
      else if (wr_field == FLD_PLL_SEL)  sel_d[wr_idx] = wr_data[SEL_W-1:0];
    end
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      tim_q   <= '0;
      flags_q <= '0;
      sel_q   <= '0;
      // slot 0 boots as 640x480p60 so the default mode has a usable entry
      tim_q[0] <= {TW'(33), TW'(2), TW'(10), TW'(480),
                   TW'(48), TW'(96), TW'(16), TW'(640)};
    end else begin
      tim_q   <= tim_d;
      flags_q <= flags_d;
      sel_q   <= sel_d;
    end
  end

  assign rd_tim   = tim_q[rd_idx];
  assign rd_flags = flags_q[rd_idx];
  assign rd_sel   = sel_q[rd_idx];

  // forward a write landing this cycle so the request judges the new value
  always_comb begin
    chk_h = tim_q[chk_idx][3'(FLD_H_DISP)];
    chk_v = tim_q[chk_idx][3'(FLD_V_DISP)];
    if (wr_en && wr_mode == chk_mode && wr_field == FLD_H_DISP) chk_h = wr_data;
    if (wr_en && wr_mode == chk_mode && wr_field == FLD_V_DISP) chk_v = wr_data;
    chk_ok = (32'(chk_mode) < NUM_MODES) && (chk_h != '0) && (chk_v != '0);
  end

endmodule

// File: rtl/vpg_mode_ctrl.sv
// Mode apply sequencer: latches a table entry, drives the PLL reconfig
// handshake, waits for lock with timeout/retry, then releases the timing gen.
module vpg_mode_ctrl
  import vpg_pkg::*;
#(
  parameter int NUM_MODES    = 8,
  parameter int MODE_W       = 3,
  parameter int TW           = 12,
  parameter int SEL_W        = 3,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int MAX_RETRY    = 3,
  parameter int TC_LEN       = 8,
  parameter int DEFAULT_MODE = 0
) (
  input  logic              clk_100,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [MODE_W-1:0] req_mode,
  input  logic              tbl_wr_en,
  input  logic [MODE_W-1:0] tbl_wr_mode,
  input  logic [3:0]        tbl_wr_field,
  input  logic [TW-1:0]     tbl_wr_data,
  input  logic              pll_busy,
  input  logic              pll_locked,
  output logic [SEL_W-1:0]  pll_sel,
  output logic              pll_write_from_rom,
  output logic              pll_reconfig,
  output logic [TW-1:0]     h_disp,
  output logic [TW-1:0]     h_fporch,
  output logic [TW-1:0]     h_sync,
  output logic [TW-1:0]     h_bporch,
  output logic [TW-1:0]     v_disp,
  output logic [TW-1:0]     v_fporch,
  output logic [TW-1:0]     v_sync,
  output logic [TW-1:0]     v_bporch,
  output logic              hs_polarity,
  output logic              vs_polarity,
  output logic              frame_interlaced,
  output logic              timing_change,
  output logic [MODE_W-1:0] active_mode,
  output logic              cfg_busy,
  output logic              err_invalid,
  output logic              err_lock
);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int RT_W = $clog2(MAX_RETRY + 1);
  localparam int TC_W = $clog2(TC_LEN + 1);

  vpg_state_e state_q, state_d;
  logic [MODE_W-1:0] target_q, target_d, active_q, active_d;
  logic [NUM_TIM-1:0][TW-1:0] tim_q, tim_d, rd_tim;
  logic [2:0] flags_q, flags_d, rd_flags;
  logic [SEL_W-1:0] sel_q, sel_d, rd_sel;
  logic wfr_q, wfr_d, rcfg_q, rcfg_d, tc_q, tc_d;
  logic err_inv_q, err_inv_d, err_lock_q, err_lock_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [RT_W-1:0] retry_q, retry_d;
  logic [TC_W-1:0] tc_cnt_q, tc_cnt_d;
  logic lock_meta_q, lock_s_q, chk_ok, in_seq;

  vpg_mode_table #(
    .NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .TW(TW), .SEL_W(SEL_W)
  ) u_tbl (
    .clk_100(clk_100), .reset_n(reset_n),
    .wr_en(tbl_wr_en), .wr_mode(tbl_wr_mode), .wr_field(tbl_wr_field),
    .wr_data(tbl_wr_data),
    .rd_mode(target_q), .rd_tim(rd_tim), .rd_flags(rd_flags), .rd_sel(rd_sel),
    .chk_mode(req_mode), .chk_ok(chk_ok)
  );

  assign in_seq = (state_q inside {ST_PLL_INIT, ST_RD, ST_RD_DONE, ST_UPD,
                                   ST_UPD_DONE, ST_WAIT_LOCK});

  always_comb begin
    state_d = state_q;  target_d = target_q;  active_d = active_q;
    tim_d = tim_q;  flags_d = flags_q;  sel_d = sel_q;
    wfr_d = wfr_q;  rcfg_d = rcfg_q;  tc_d = tc_q;
    err_inv_d = 1'b0;  err_lock_d = err_lock_q;
    to_cnt_d = to_cnt_q;  retry_d = retry_q;  tc_cnt_d = tc_cnt_q;
    case (state_q)
      ST_LOAD: begin
        tim_d = rd_tim;  flags_d = rd_flags;  sel_d = rd_sel;
        active_d = target_q;  tc_d = 1'b1;  to_cnt_d = '0;
        state_d = ST_PLL_INIT;
      end
      ST_PLL_INIT: begin wfr_d = 1'b0; rcfg_d = 1'b0; state_d = ST_RD; end
      ST_RD:       if (!pll_busy) begin wfr_d = 1'b1;  state_d = ST_RD_DONE;  end
      ST_RD_DONE:  if (!pll_busy) begin wfr_d = 1'b0;  state_d = ST_UPD;      end
      ST_UPD:      if (!pll_busy) begin rcfg_d = 1'b1; state_d = ST_UPD_DONE; end
      ST_UPD_DONE: if (!pll_busy) begin rcfg_d = 1'b0; state_d = ST_WAIT_LOCK; end
      ST_WAIT_LOCK: if (lock_s_q) begin
        tc_cnt_d = TC_W'(TC_LEN - 1);
        state_d  = ST_START;
      end
      ST_START: begin
        if (tc_cnt_q == '0) begin tc_d = 1'b0; state_d = ST_IDLE; end
        else tc_cnt_d = tc_cnt_q - 1'b1;
      end
      // lock loss while running re-enters the lock wait without a retry
      ST_IDLE: if (!lock_s_q) begin
        tc_d = 1'b1;  to_cnt_d = '0;  state_d = ST_WAIT_LOCK;
      end
      ST_ERROR: tc_d = 1'b1;
      default:  state_d = ST_ERROR;
    endcase
    if (in_seq && !(state_q == ST_WAIT_LOCK && lock_s_q)) begin
      if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
        wfr_d = 1'b0;  rcfg_d = 1'b0;  to_cnt_d = '0;
        if (retry_q != RT_W'(MAX_RETRY)) retry_d = retry_q + 1'b1;
        if (32'(retry_q) + 1 < MAX_RETRY) state_d = ST_PLL_INIT;
        else begin state_d = ST_ERROR; err_lock_d = 1'b1; end
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
    // a valid request pre-empts whatever the sequencer was doing
    if (req_valid) begin
      if (chk_ok) begin
        target_d = req_mode;  state_d = ST_LOAD;
        wfr_d = 1'b0;  rcfg_d = 1'b0;  retry_d = '0;  err_lock_d = 1'b0;
        to_cnt_d = '0;
      end else begin
        err_inv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;  lock_s_q <= 1'b0;
      state_q  <= ST_LOAD;
      target_q <= MODE_W'(DEFAULT_MODE);
      active_q <= MODE_W'(DEFAULT_MODE);
      tim_q <= '0;  flags_q <= '0;  sel_q <= '0;
      wfr_q <= 1'b0;  rcfg_q <= 1'b0;  tc_q <= 1'b1;
      err_inv_q <= 1'b0;  err_lock_q <= 1'b0;
      to_cnt_q <= '0;  retry_q <= '0;  tc_cnt_q <= '0;
    end else begin
      lock_meta_q <= pll_locked;  lock_s_q <= lock_meta_q;
      state_q <= state_d;  target_q <= target_d;  active_q <= active_d;
      tim_q <= tim_d;  flags_q <= flags_d;  sel_q <= sel_d;
      wfr_q <= wfr_d;  rcfg_q <= rcfg_d;  tc_q <= tc_d;
      err_inv_q <= err_inv_d;  err_lock_q <= err_lock_d;
      to_cnt_q <= to_cnt_d;  retry_q <= retry_d;  tc_cnt_q <= tc_cnt_d;
    end
  end

  assign h_disp   = tim_q[0];
  assign h_fporch = tim_q[1];
  assign h_sync   = tim_q[2];
  assign h_bporch = tim_q[3];
  assign v_disp   = tim_q[4];
  assign v_fporch = tim_q[5];
  assign v_sync   = tim_q[6];
  assign v_bporch = tim_q[7];
  assign {frame_interlaced, vs_polarity, hs_polarity} = flags_q;
  assign pll_sel            = sel_q;
  assign pll_write_from_rom = wfr_q;
  assign pll_reconfig       = rcfg_q;
  assign timing_change      = tc_q;
  assign active_mode        = active_q;
  assign cfg_busy           = !(state_q inside {ST_IDLE, ST_ERROR});
  assign err_invalid        = err_inv_q;
  assign err_lock           = err_lock_q;

endmodule
